// File: rtl/uart_stream_pkg.sv
// Purpose  : shared FSM state type, UART register map and control bit positions for the TX streamer.
// Latency  : n/a (declarations only).
// Backpres.: n/a.
// Optional : UART_STREAM_RX_EN adds the RX_RD / RX_CLR states to the state enum.
package uart_stream_pkg;

   // UART register interface map
   localparam logic [1:0] ADDR_CTRL   = 2'b00;
   localparam logic [1:0] ADDR_TXDATA = 2'b01;
   localparam logic [1:0] ADDR_RXDATA = 2'b11;

   // Control register bits
   localparam int CTRL_SEND_BIT  = 0;
   localparam int CTRL_NEWRX_BIT = 1;

   // Value written to the control register to start a send
   localparam logic [31:0] CTRL_START = 32'd1;

   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      WR_CTRL,
      GUARD,
      POLL
`ifdef UART_STREAM_RX_EN
      ,
      RX_RD,
      RX_CLR
`endif
   } state_t;

   // Zero-extend a byte to a UART data-bus word
   function automatic logic [31:0] byte_word(input logic [7:0] b);
      return {24'd0, b};
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Purpose  : byte FIFO, DEPTH entries (power of two), pointers wrap modulo DEPTH.
// Latency  : a pushed byte is visible at rdata the cycle after the push (show-ahead head).
// Backpres.: push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
// Ports    : clk/rst (async active-high), push/wdata in, pop in, rdata = head,
//            full/empty flags, count = bytes held ($clog2(DEPTH)+1 bits).
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full  = (count == DEPTH[AW:0]);
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push then
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage has no reset; only the pointers and count define validity
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointer width is exactly log2(DEPTH), so increments wrap modulo DEPTH
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_streamer.sv
// Purpose  : drains a CPU-filled byte FIFO into a UART register interface (data write, start write, poll busy).
// Latency  : first uart_we_o two cycles after a push into an empty FIFO while idle; one byte per send.
// Backpres.: pushes beyond DEPTH are dropped and latch overflow_o; POLL holds while the UART send bit is set.
// Ports    : clk_pi, rst (async active-high); push_i/push_data_i CPU write; full_o/empty_o/count_o/overflow_o
//            FIFO status; busy_o = not IDLE; uart_we_o/uart_addr_o/uart_data_o register writes/reads,
//            uart_data_i combinational read data.
// Optional : UART_STREAM_RX_EN adds rx_valid_o/rx_data_o and RX capture (RX_RD, RX_CLR), taking priority over TX.
import uart_stream_pkg::*;

module uart_tx_streamer #(
   parameter int DEPTH = 16
) (
   input  logic                     clk_pi,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [7:0]               push_data_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   output logic                     busy_o,
   output logic                     uart_we_o,
   output logic [1:0]               uart_addr_o,
   output logic [31:0]              uart_data_o,
   input  logic [31:0]              uart_data_i
`ifdef UART_STREAM_RX_EN
   ,
   output logic                     rx_valid_o,
   output logic [7:0]               rx_data_o
`endif
);

   state_t     state;
   logic [7:0] fifo_head;
   logic       fifo_pop;
   logic       rx_req;

`ifdef UART_STREAM_RX_EN
   assign rx_req = uart_data_i[CTRL_NEWRX_BIT];
   logic unused_rdata;
   assign unused_rdata = ^uart_data_i[31:8];
`else
   // New-RX flag is ignored without RX capture
   assign rx_req = 1'b0;
   logic unused_rdata;
   assign unused_rdata = ^uart_data_i[31:1];
`endif

   // The head is consumed on the IDLE->WR_DATA edge, the same edge that registers it onto uart_data_o
   assign fifo_pop = (state == IDLE) && !empty_o && !rx_req;
   assign busy_o   = (state != IDLE);

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk_pi),
      .rst   (rst),
      .push  (push_i),
      .wdata (push_data_i),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (full_o),
      .empty (empty_o),
      .count (count_o)
   );

   // Sticky: a push that found the FIFO full with no simultaneous pop was lost
   always_ff @(posedge clk_pi or posedge rst) begin
      if (rst) begin
         overflow_o <= 1'b0;
      end else if (push_i && full_o && !fifo_pop) begin
         overflow_o <= 1'b1;
      end
   end

   // Outputs are registered together with the state: each transition loads the
   // bus values belonging to the state being entered.
   always_ff @(posedge clk_pi or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         uart_we_o   <= 1'b0;
         uart_addr_o <= ADDR_CTRL;
         uart_data_o <= '0;
`ifdef UART_STREAM_RX_EN
         rx_valid_o  <= 1'b0;
         rx_data_o   <= '0;
`endif
      end else begin
`ifdef UART_STREAM_RX_EN
         rx_valid_o <= 1'b0;
`endif
         case (state)
            IDLE: begin
`ifdef UART_STREAM_RX_EN
               if (rx_req) begin
                  state       <= RX_RD;
                  uart_we_o   <= 1'b0;
                  uart_addr_o <= ADDR_RXDATA;
                  uart_data_o <= '0;
               end else
`endif
               if (!empty_o) begin
                  state       <= WR_DATA;
                  uart_we_o   <= 1'b1;
                  uart_addr_o <= ADDR_TXDATA;
                  uart_data_o <= byte_word(fifo_head);
               end else begin
                  uart_we_o   <= 1'b0;
                  uart_addr_o <= ADDR_CTRL;
                  uart_data_o <= '0;
               end
            end

            WR_DATA: begin
               state       <= WR_CTRL;
               uart_we_o   <= 1'b1;
               uart_addr_o <= ADDR_CTRL;
               uart_data_o <= CTRL_START;
            end

            // GUARD gives the UART one cycle to raise its send bit before we poll it
            WR_CTRL: begin
               state       <= GUARD;
               uart_we_o   <= 1'b0;
               uart_addr_o <= ADDR_CTRL;
               uart_data_o <= '0;
            end

            GUARD: begin
               state       <= POLL;
               uart_we_o   <= 1'b0;
               uart_addr_o <= ADDR_CTRL;
               uart_data_o <= '0;
            end

            // No timeout: a stuck send bit parks the streamer here
            POLL: begin
               uart_we_o   <= 1'b0;
               uart_addr_o <= ADDR_CTRL;
               uart_data_o <= '0;
               if (!uart_data_i[CTRL_SEND_BIT]) begin
                  state <= IDLE;
               end
            end

`ifdef UART_STREAM_RX_EN
            RX_RD: begin
               rx_data_o   <= uart_data_i[7:0];
               rx_valid_o  <= 1'b1;
               state       <= RX_CLR;
               uart_we_o   <= 1'b1;
               uart_addr_o <= ADDR_CTRL;
               uart_data_o <= '0;
            end

            RX_CLR: begin
               state       <= IDLE;
               uart_we_o   <= 1'b0;
               uart_addr_o <= ADDR_CTRL;
               uart_data_o <= '0;
            end
`endif

            default: begin
               state       <= IDLE;
               uart_we_o   <= 1'b0;
               uart_addr_o <= ADDR_CTRL;
               uart_data_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Purpose  : self-checking bench for uart_tx_streamer with a behavioural UART register model.
// Latency  : n/a.
// Backpres.: n/a.
// Optional : UART_STREAM_RX_EN enables the RX capture scenario and ports.
module tb_uart_tx_streamer;

   localparam int DEPTH = 16;

   logic        clk_pi = 1'b0;
   logic        rst;
   logic        push_i;
   logic [7:0]  push_data_i;
   logic        full_o;
   logic        empty_o;
   logic [4:0]  count_o;
   logic        overflow_o;
   logic        busy_o;
   logic        uart_we_o;
   logic [1:0]  uart_addr_o;
   logic [31:0] uart_data_o;
   logic [31:0] uart_data_i;
`ifdef UART_STREAM_RX_EN
   logic        rx_valid_o;
   logic [7:0]  rx_data_o;
`endif

   always #5 clk_pi = ~clk_pi;

   uart_tx_streamer #(.DEPTH(DEPTH)) dut (
      .clk_pi      (clk_pi),
      .rst         (rst),
      .push_i      (push_i),
      .push_data_i (push_data_i),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .count_o     (count_o),
      .overflow_o  (overflow_o),
      .busy_o      (busy_o),
      .uart_we_o   (uart_we_o),
      .uart_addr_o (uart_addr_o),
      .uart_data_o (uart_data_o),
      .uart_data_i (uart_data_i)
`ifdef UART_STREAM_RX_EN
      ,
      .rx_valid_o  (rx_valid_o),
      .rx_data_o   (rx_data_o)
`endif
   );

   // ---------------- UART register model ----------------
   int         send_cnt;
   int         send_delay;
   logic       clr_send;
   logic       set_rx;
   logic       new_rx;
   logic [7:0] rx_byte;

   always @(posedge clk_pi) begin
      if (rst || clr_send)
         send_cnt <= 0;
      else if (uart_we_o && uart_addr_o == 2'b00 && uart_data_o[0])
         send_cnt <= send_delay;
      else if (send_cnt > 0)
         send_cnt <= send_cnt - 1;

      if (rst)
         new_rx <= 1'b0;
      else if (set_rx)
         new_rx <= 1'b1;
      else if (uart_we_o && uart_addr_o == 2'b00 && !uart_data_o[1])
         new_rx <= 1'b0;
   end

   assign uart_data_i = (uart_addr_o == 2'b00) ? {30'd0, new_rx, (send_cnt != 0)} :
                        (uart_addr_o == 2'b11) ? {24'd0, rx_byte} : 32'd0;

   // ---------------- checking ----------------
   int tests = 0;
   int fails = 0;
   int wr_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the FIFO is a byte queue; every TX data write must carry its head,
   // be followed immediately by a start write, and all other cycles drive zero data.
   logic [7:0] q[$];
   logic       m_ovf;
   logic       exp_ctrl;
   logic       lp;
   logic [7:0] ld;
   logic [7:0] b;

   initial begin : compare
      m_ovf    = 1'b0;
      exp_ctrl = 1'b0;
      forever begin
         @(posedge clk_pi);
         lp = push_i;
         ld = push_data_i;
         #2;
         if (rst) begin
            q.delete();
            m_ovf    = 1'b0;
            exp_ctrl = 1'b0;
            check("rst_we", 32'(uart_we_o), 32'd0);
            check("rst_data", uart_data_o, 32'd0);
            check("rst_count", 32'(count_o), 32'd0);
         end else begin
            if (uart_we_o) begin
               wr_seen++;
               if (uart_addr_o == 2'b01) begin
                  check("ctrl_before_data", 32'(exp_ctrl), 32'd0);
                  check("pop_nonempty", 32'(q.size() != 0), 32'd1);
                  if (q.size() != 0) begin
                     b = q.pop_front();
                     check("tx_byte", uart_data_o, {24'd0, b});
                  end
                  exp_ctrl = 1'b1;
               end else if (uart_addr_o == 2'b00) begin
                  check("ctrl_word", uart_data_o, exp_ctrl ? 32'd1 : 32'd0);
                  exp_ctrl = 1'b0;
               end else begin
                  check("we_addr", 32'(uart_addr_o), 32'd0);
               end
            end else begin
               check("idle_data", uart_data_o, 32'd0);
               check("ctrl_follows", 32'(exp_ctrl), 32'd0);
               exp_ctrl = 1'b0;
            end
            if (lp) begin
               if (q.size() < DEPTH) q.push_back(ld);
               else m_ovf = 1'b1;
            end
            check("count", 32'(count_o), 32'(q.size()));
            check("full", 32'(full_o), 32'(q.size() == DEPTH));
            check("empty", 32'(empty_o), 32'(q.size() == 0));
            check("overflow", 32'(overflow_o), 32'(m_ovf));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge clk_pi);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   int n;
   int w0;

   initial begin : stim
      rst = 1'b1; push_i = 1'b0; push_data_i = 8'h00;
      set_rx = 1'b0; clr_send = 1'b0; send_delay = 4; rx_byte = 8'h5A;
      repeat (3) cyc();
      check("reset_empty", 32'(empty_o), 32'd1);
      check("reset_full", 32'(full_o), 32'd0);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_addr", 32'(uart_addr_o), 32'd0);
      check("reset_ovf", 32'(overflow_o), 32'd0);
      rst = 1'b0;
      cyc();

      // Single byte: latency, write pair, busy release
      w0 = wr_seen;
      push_i = 1'b1; push_data_i = 8'h41; cyc(); push_i = 1'b0;
      check("lat_no_we_yet", 32'(uart_we_o), 32'd0);
      check("lat_count1", 32'(count_o), 32'd1);
      cyc();
      check("wrdata_we", 32'(uart_we_o), 32'd1);
      check("wrdata_addr", 32'(uart_addr_o), 32'd1);
      check("wrdata_val", uart_data_o, 32'h41);
      check("wrdata_busy", 32'(busy_o), 32'd1);
      cyc();
      check("wrctrl_we", 32'(uart_we_o), 32'd1);
      check("wrctrl_addr", 32'(uart_addr_o), 32'd0);
      check("wrctrl_val", uart_data_o, 32'd1);
      cyc();
      check("guard_we", 32'(uart_we_o), 32'd0);
      repeat (4) cyc();
      check("poll_hold", 32'(busy_o), 32'd1);
      cyc();
      check("poll_release", 32'(busy_o), 32'd0);
      check("single_writes", 32'(wr_seen - w0), 32'd2);

      // Fill to full while a long send is in progress, then push+pop, then overflow
      send_delay = 200;
      w0 = wr_seen;
      push_i = 1'b1; push_data_i = 8'hEE; cyc(); push_i = 1'b0;
      repeat (3) cyc();
      for (int i = 1; i <= 16; i++) begin
         push_i = 1'b1; push_data_i = 8'(i); cyc();
      end
      push_i = 1'b0;
      check("fill_full", 32'(full_o), 32'd1);
      check("fill_count", 32'(count_o), 32'd16);
      check("fill_no_ovf", 32'(overflow_o), 32'd0);
      clr_send = 1'b1; cyc(); clr_send = 1'b0;
      n = 0;
      while (busy_o && n < 20) begin cyc(); n++; end
      check("full_release", 32'(busy_o), 32'd0);
      push_i = 1'b1; push_data_i = 8'h11; cyc();
      check("pushpop_count", 32'(count_o), 32'd16);
      check("pushpop_ovf", 32'(overflow_o), 32'd0);
      check("pushpop_head", uart_data_o, 32'h01);
      push_data_i = 8'h12; cyc(); push_i = 1'b0;
      check("overflow_set", 32'(overflow_o), 32'd1);
      check("overflow_count", 32'(count_o), 32'd16);
      send_delay = 2;
      n = 0;
      while (!(empty_o && !busy_o) && n < 2000) begin cyc(); n++; end
      check("drain_done", 32'(empty_o && !busy_o), 32'd1);
      check("drain_writes", 32'(wr_seen - w0), 32'd36);

      // Reset during POLL with three bytes queued
      send_delay = 200;
      for (int i = 0; i < 4; i++) begin
         push_i = 1'b1; push_data_i = 8'(8'hA0 + i); cyc();
      end
      push_i = 1'b0;
      cyc();
      check("prerst_count", 32'(count_o), 32'd3);
      check("prerst_busy", 32'(busy_o), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_empty", 32'(empty_o), 32'd1);
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_we", 32'(uart_we_o), 32'd0);
      cyc();
      rst = 1'b0;
      w0 = wr_seen;
      repeat (20) cyc();
      check("postrst_writes", 32'(wr_seen - w0), 32'd0);
      check("postrst_empty", 32'(empty_o), 32'd1);

`ifdef UART_STREAM_RX_EN
      // RX capture takes priority over a queued TX byte
      send_delay = 4;
      set_rx = 1'b1; push_i = 1'b1; push_data_i = 8'h33; cyc();
      set_rx = 1'b0; push_i = 1'b0;
      check("rx_pre_idle", 32'(busy_o), 32'd0);
      cyc();
      check("rx_rd_addr", 32'(uart_addr_o), 32'd3);
      check("rx_rd_count", 32'(count_o), 32'd1);
      cyc();
      check("rx_valid", 32'(rx_valid_o), 32'd1);
      check("rx_data", 32'(rx_data_o), 32'h5A);
      check("rx_clr_we", 32'(uart_we_o), 32'd1);
      check("rx_clr_val", uart_data_o, 32'd0);
      cyc();
      check("rx_pulse_end", 32'(rx_valid_o), 32'd0);
      cyc();
      check("rx_then_tx", uart_data_o, 32'h33);
      n = 0;
      while (!(empty_o && !busy_o) && n < 200) begin cyc(); n++; end
      check("rx_drain", 32'(empty_o && !busy_o), 32'd1);
`endif

      repeat (3) cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
